// File: rtl/char_pkg.sv
// char_pkg
//   Shared constants and types for the character plotter:
//   cell geometry, framebuffer bounds, background colour,
//   5-bit glyph codes (A=0 .. Z=25) and the plotter state type.
package char_pkg;

    localparam int CELL_W   = 8;
    localparam int CELL_H   = 10;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam int DX_W = $clog2(CELL_W);
    localparam int DY_W = $clog2(CELL_H);

    localparam logic [5:0] BG_COLOUR = 6'b000000;

    localparam logic [4:0] GLYPH_A = 5'd0;
    localparam logic [4:0] GLYPH_B = 5'd1;
    localparam logic [4:0] GLYPH_C = 5'd2;
    localparam logic [4:0] GLYPH_D = 5'd3;
    localparam logic [4:0] GLYPH_E = 5'd4;
    localparam logic [4:0] GLYPH_F = 5'd5;
    localparam logic [4:0] GLYPH_G = 5'd6;
    localparam logic [4:0] GLYPH_H = 5'd7;
    localparam logic [4:0] GLYPH_I = 5'd8;
    localparam logic [4:0] GLYPH_J = 5'd9;
    localparam logic [4:0] GLYPH_K = 5'd10;
    localparam logic [4:0] GLYPH_L = 5'd11;
    localparam logic [4:0] GLYPH_M = 5'd12;
    localparam logic [4:0] GLYPH_N = 5'd13;
    localparam logic [4:0] GLYPH_O = 5'd14;
    localparam logic [4:0] GLYPH_P = 5'd15;
    localparam logic [4:0] GLYPH_Q = 5'd16;
    localparam logic [4:0] GLYPH_R = 5'd17;
    localparam logic [4:0] GLYPH_S = 5'd18;
    localparam logic [4:0] GLYPH_T = 5'd19;
    localparam logic [4:0] GLYPH_U = 5'd20;
    localparam logic [4:0] GLYPH_V = 5'd21;
    localparam logic [4:0] GLYPH_W = 5'd22;
    localparam logic [4:0] GLYPH_X = 5'd23;
    localparam logic [4:0] GLYPH_Y = 5'd24;
    localparam logic [4:0] GLYPH_Z = 5'd25;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } plot_state_t;

endpackage

// File: rtl/char_cell_scanner.sv
// char_cell_scanner
//   Row-major dx/dy counter over one CELL_W x CELL_H cell.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : return to (0,0) (takes priority over advance)
//   advance    : step to the next pixel; the final pixel wraps to (0,0)
//   dx, dy     : current pixel offset within the cell
//   last       : high while at (CELL_W-1, CELL_H-1)
module char_cell_scanner
    import char_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            advance,
    output logic [DX_W-1:0] dx,
    output logic [DY_W-1:0] dy,
    output logic            last
);

    logic [DX_W-1:0] dx_reg;
    logic [DY_W-1:0] dy_reg;
    logic            dx_end;
    logic            dy_end;

    assign dx_end = (dx_reg == DX_W'(CELL_W - 1));
    assign dy_end = (dy_reg == DY_W'(CELL_H - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dx_reg <= '0;
            dy_reg <= '0;
        end else if (clear) begin
            dx_reg <= '0;
            dy_reg <= '0;
        end else if (advance) begin
            if (dx_end) begin
                dx_reg <= '0;
                dy_reg <= dy_end ? '0 : dy_reg + DY_W'(1);
            end else begin
                dx_reg <= dx_reg + DX_W'(1);
            end
        end
    end

    assign dx   = dx_reg;
    assign dy   = dy_reg;
    assign last = dx_end && dy_end;

endmodule

// File: rtl/char_plotter.sv
// char_plotter
//   Sweeps one 8x10 character cell at a screen origin and issues
//   registered framebuffer writes under a valid/ready handshake.
//   clk, reset                  : clock, asynchronous active-high reset
//   start                       : request, accepted only in IDLE
//   char_code, org_x, org_y,
//   opaque                      : cell parameters latched on accepted start
//   glyph_sel, glyph_x, glyph_y : latched parameters to the decoder bank
//   flush_x, flush_y            : current scan point (origin + offset, mod 256)
//   glyph_colour, glyph_enable  : decoder response for the current scan point
//   plot_x, plot_y, plot_colour,
//   plot_valid, plot_ready      : framebuffer write port
//   busy                        : high whenever not IDLE
//   done                        : one-cycle pulse after the final write is taken
module char_plotter
    import char_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] char_code,
    input  logic [7:0] org_x,
    input  logic [7:0] org_y,
    input  logic       opaque,
    output logic [4:0] glyph_sel,
    output logic [7:0] glyph_x,
    output logic [7:0] glyph_y,
    output logic [7:0] flush_x,
    output logic [7:0] flush_y,
    input  logic [5:0] glyph_colour,
    input  logic       glyph_enable,
    output logic [7:0] plot_x,
    output logic [7:0] plot_y,
    output logic [5:0] plot_colour,
    output logic       plot_valid,
    input  logic       plot_ready,
    output logic       busy,
    output logic       done
);

    plot_state_t state_reg, state_next;

    logic [4:0] glyph_sel_reg;
    logic [7:0] glyph_x_reg;
    logic [7:0] glyph_y_reg;
    logic       opaque_reg;

    logic [7:0] plot_x_reg;
    logic [7:0] plot_y_reg;
    logic [5:0] plot_colour_reg;
    logic       plot_valid_reg;

    logic [DX_W-1:0] dx;
    logic [DY_W-1:0] dy;
    logic            last;

    logic start_accept;
    logic can_advance;
    logic scan_advance;
    logic write_en;

    // Output slot is free when empty or being consumed this cycle.
    assign can_advance  = !plot_valid_reg || plot_ready;
    assign start_accept = (state_reg == ST_IDLE) && start;
    assign scan_advance = (state_reg == ST_SCAN) && can_advance;

    char_cell_scanner u_scanner (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_accept),
        .advance (scan_advance),
        .dx      (dx),
        .dy      (dy),
        .last    (last)
    );

    // Per-axis scan point and visibility. Axis 0 is x, axis 1 is y.
    // A carry out of origin+offset means the pixel wrapped past 255,
    // so it is off screen even if the wrapped value looks small.
    logic [1:0][7:0] axis_org;
    logic [1:0][7:0] axis_off;
    logic [1:0][7:0] axis_pos;
    logic [1:0]      axis_ok;

    assign axis_org[0] = glyph_x_reg;
    assign axis_org[1] = glyph_y_reg;
    assign axis_off[0] = {{(8 - DX_W){1'b0}}, dx};
    assign axis_off[1] = {{(8 - DY_W){1'b0}}, dy};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            localparam logic [7:0] LIMIT = (gi == 0) ? 8'(SCREEN_W) : 8'(SCREEN_H);
            logic [8:0] sum;
            assign sum          = {1'b0, axis_org[gi]} + {1'b0, axis_off[gi]};
            assign axis_pos[gi] = sum[7:0];
            assign axis_ok[gi]  = !sum[8] && (sum[7:0] < LIMIT);
        end
    endgenerate

    assign write_en = (glyph_enable || opaque_reg) && axis_ok[0] && axis_ok[1];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_SCAN;
            ST_SCAN:  if (can_advance && last) state_next = ST_DRAIN;
            ST_DRAIN: if (can_advance) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy = (state_reg != ST_IDLE);
        done = (state_reg == ST_DONE);
    end

    // Latched cell parameters and the registered write slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glyph_sel_reg   <= '0;
            glyph_x_reg     <= '0;
            glyph_y_reg     <= '0;
            opaque_reg      <= 1'b0;
            plot_x_reg      <= '0;
            plot_y_reg      <= '0;
            plot_colour_reg <= '0;
            plot_valid_reg  <= 1'b0;
        end else begin
            if (start_accept) begin
                glyph_sel_reg <= char_code;
                glyph_x_reg   <= org_x;
                glyph_y_reg   <= org_y;
                opaque_reg    <= opaque;
            end
            if (scan_advance) begin
                if (write_en) begin
                    plot_x_reg      <= axis_pos[0];
                    plot_y_reg      <= axis_pos[1];
                    plot_colour_reg <= glyph_enable ? glyph_colour : BG_COLOUR;
                    plot_valid_reg  <= 1'b1;
                end else begin
                    plot_valid_reg  <= 1'b0;
                end
            end else if (can_advance) begin
                // Pending write accepted (or slot already empty) outside SCAN.
                plot_valid_reg <= 1'b0;
            end
        end
    end

    assign glyph_sel   = glyph_sel_reg;
    assign glyph_x     = glyph_x_reg;
    assign glyph_y     = glyph_y_reg;
    assign flush_x     = axis_pos[0];
    assign flush_y     = axis_pos[1];
    assign plot_x      = plot_x_reg;
    assign plot_y      = plot_y_reg;
    assign plot_colour = plot_colour_reg;
    assign plot_valid  = plot_valid_reg;

endmodule

// File: tb/tb_char_plotter.sv
// tb_char_plotter
//   Self-checking bench for char_plotter. A behavioural glyph decoder
//   answers the scan points; expected write lists are built from the
//   cell geometry and clipping rules with plain integer loops.
module tb_char_plotter;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] char_code;
    logic [7:0] org_x, org_y;
    logic       opaque;
    logic [4:0] glyph_sel;
    logic [7:0] glyph_x, glyph_y, flush_x, flush_y;
    logic [5:0] glyph_colour;
    logic       glyph_enable;
    logic [7:0] plot_x, plot_y;
    logic [5:0] plot_colour;
    logic       plot_valid;
    logic       plot_ready;
    logic       busy, done;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [5:0] c;
    } wr_t;

    wr_t acc_q[$];
    wr_t exp_q[$];
    int  cyc = 0;
    int  done_cnt = 0;
    int  last_done_cyc = -1;
    int  stall_cnt = 0;
    int  checks = 0;
    int  errors = 0;

    char_plotter dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .char_code    (char_code),
        .org_x        (org_x),
        .org_y        (org_y),
        .opaque       (opaque),
        .glyph_sel    (glyph_sel),
        .glyph_x      (glyph_x),
        .glyph_y      (glyph_y),
        .flush_x      (flush_x),
        .flush_y      (flush_y),
        .glyph_colour (glyph_colour),
        .glyph_enable (glyph_enable),
        .plot_x       (plot_x),
        .plot_y       (plot_y),
        .plot_colour  (plot_colour),
        .plot_valid   (plot_valid),
        .plot_ready   (plot_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Font: returns {enable, colour[5:0]} for offset (dx,dy) of a glyph.
    // 'J' is a real bitmap with 17 lit pixels; other codes use a pattern.
    function automatic logic [6:0] font_px(input logic [4:0] code, input int dx, input int dy);
        logic [7:0] row;
        int         lit;
        if (dx < 0 || dx > 7 || dy < 0 || dy > 9) return 7'd0;
        if (code == 5'd9) begin
            case (dy)
                0:       row = 8'hE0;
                8:       row = 8'h23;
                9:       row = 8'h3C;
                default: row = 8'h20;
            endcase
            lit = int'(row[dx]);
            return lit != 0 ? 7'h7F : 7'h00;
        end
        lit = ((dx + 2 * dy + int'(code)) % 3 == 0) ? 1 : 0;
        if (lit == 0) return 7'h00;
        return {1'b1, 6'((int'(code) * 5 + dx * 3 + dy * 7) % 63 + 1)};
    endfunction

    // Decoder bank stand-in, answering combinationally.
    logic [7:0] dec_dx, dec_dy;
    logic [6:0] dec_px;
    always_comb begin
        dec_dx       = flush_x - glyph_x;
        dec_dy       = flush_y - glyph_y;
        dec_px       = font_px(glyph_sel, int'(dec_dx), int'(dec_dy));
        glyph_enable = dec_px[6];
        glyph_colour = dec_px[5:0];
    end

    // Write/done monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (plot_valid && plot_ready) acc_q.push_back('{plot_x, plot_y, plot_colour});
            if (plot_valid && !plot_ready) stall_cnt++;
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
        end
    end

    // Reference: every visible pixel of the cell in row-major order.
    task automatic build_exp(input logic [4:0] code, input int ox, input int oy, input logic opq);
        logic [6:0] px;
        exp_q.delete();
        for (int dy = 0; dy < 10; dy++) begin
            for (int dx = 0; dx < 8; dx++) begin
                px = font_px(code, dx, dy);
                if ((px[6] || opq) && (ox + dx) < 160 && (oy + dy) < 120)
                    exp_q.push_back('{8'(ox + dx), 8'(oy + dy), px[6] ? px[5:0] : 6'h00});
            end
        end
    endtask

    function automatic int seq_mismatch();
        int m = 0;
        int n;
        if (acc_q.size() != exp_q.size()) m++;
        n = (acc_q.size() < exp_q.size()) ? acc_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (acc_q[i] !== exp_q[i]) m++;
        return m;
    endfunction

    // Runs one cell. Returns done latency (cycles after start) or -1 on timeout.
    task automatic run_cell(input logic [4:0] code, input logic [7:0] ox, input logic [7:0] oy,
                            input logic opq, input bit rand_ready, input int stall_idx,
                            input int stall_len, input bit spam,
                            output int done_lat, output int stall_bad, output int latch_bad);
        int  c0, d0, held;
        bit  stalled, got;
        logic [7:0] sx, sy;
        logic [5:0] sc;
        acc_q.delete();
        stall_cnt = 0;
        stall_bad = 0;
        latch_bad = 0;
        held = 0;
        stalled = 0;
        got = 0;
        build_exp(code, int'(ox), int'(oy), opq);
        @(posedge clk); #1;
        d0 = done_cnt;
        plot_ready = 1'b1;
        start = 1'b1; char_code = code; org_x = ox; org_y = oy; opaque = opq;
        c0 = cyc;
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk); #1;
            if (done_cnt != d0) begin
                got = 1;
                break;
            end
            if (spam && (cyc - c0) <= 50) begin
                start = 1'b1;
                char_code = 5'($urandom); org_x = 8'($urandom); org_y = 8'($urandom);
                opaque = 1'($urandom);
            end else begin
                start = 1'b0; char_code = code; org_x = ox; org_y = oy; opaque = opq;
            end
            if (busy && (glyph_sel !== code || glyph_x !== ox || glyph_y !== oy)) latch_bad++;
            if (rand_ready) begin
                plot_ready = ($urandom_range(0, 3) != 0);
            end else if (stall_len > 0 && !stalled && plot_valid && acc_q.size() == stall_idx) begin
                stalled = 1; plot_ready = 1'b0; held = 1;
                sx = plot_x; sy = plot_y; sc = plot_colour;
            end else if (held > 0) begin
                if (!plot_valid || plot_x !== sx || plot_y !== sy || plot_colour !== sc) stall_bad++;
                if (held == stall_len) begin
                    plot_ready = 1'b1;
                    held = 0;
                end else begin
                    held++;
                end
            end
        end
        start = 1'b0;
        plot_ready = 1'b1;
        done_lat = got ? (last_done_cyc - c0) : -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, plot_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: busy/done/valid got %b want 000", {busy, done, plot_valid});
        end
        checks++;
        if ({plot_x, plot_y, plot_colour} !== 22'd0) begin
            errors++;
            $display("FAIL reset_plot: x=%0d y=%0d c=%h want 0", plot_x, plot_y, plot_colour);
        end
        checks++;
        if ({glyph_sel, glyph_x, glyph_y} !== 21'd0) begin
            errors++;
            $display("FAIL reset_latch: sel=%0d x=%0d y=%0d want 0", glyph_sel, glyph_x, glyph_y);
        end
        reset = 1'b0;
        $display("reset: busy=%b done=%b valid=%b", busy, done, plot_valid);
    endtask

    task automatic test_transparent_j();
        int lat, sb, lb, m;
        run_cell(5'd9, 8'd10, 8'd20, 1'b0, 0, 0, 0, 0, lat, sb, lb);
        m = seq_mismatch();
        checks++;
        if (acc_q.size() != 17) begin
            errors++;
            $display("FAIL j_count: got %0d writes want 17", acc_q.size());
        end
        checks++;
        if (acc_q.size() == 0 || acc_q[0] !== wr_t'{8'd15, 8'd20, 6'h3F}) begin
            errors++;
            $display("FAIL j_first: got %h want (15,20,3F)", acc_q.size() ? acc_q[0] : wr_t'(0));
        end
        checks++;
        if (acc_q.size() == 0 || acc_q[$] !== wr_t'{8'd15, 8'd29, 6'h3F}) begin
            errors++;
            $display("FAIL j_last: got %h want (15,29,3F)", acc_q.size() ? acc_q[$] : wr_t'(0));
        end
        checks++;
        if (m != 0) begin
            errors++;
            $display("FAIL j_seq: %0d mismatches want 0", m);
        end
        checks++;
        if (lat != 82) begin
            errors++;
            $display("FAIL j_done: done at cycle %0d want 82", lat);
        end
        $display("transparent J @(10,20): writes=%0d done_cycle=%0d", acc_q.size(), lat);
    endtask

    task automatic test_opaque_j();
        int lat, sb, lb, m, lit;
        run_cell(5'd9, 8'd0, 8'd0, 1'b1, 0, 0, 0, 0, lat, sb, lb);
        m = seq_mismatch();
        lit = 0;
        foreach (acc_q[i]) if (acc_q[i].c == 6'h3F) lit++;
        checks++;
        if (acc_q.size() != 80 || lit != 17) begin
            errors++;
            $display("FAIL opaque_count: got %0d writes/%0d lit want 80/17", acc_q.size(), lit);
        end
        checks++;
        if (m != 0) begin
            errors++;
            $display("FAIL opaque_seq: %0d mismatches want 0", m);
        end
        $display("opaque J @(0,0): writes=%0d lit=%0d done_cycle=%0d", acc_q.size(), lit, lat);
    endtask

    task automatic test_clip();
        int lat, sb, lb, m, bad;
        run_cell(5'($urandom_range(0, 25)), 8'd155, 8'd115, 1'b1, 0, 0, 0, 0, lat, sb, lb);
        m = seq_mismatch();
        bad = 0;
        foreach (acc_q[i]) if (acc_q[i].x >= 160 || acc_q[i].y >= 120) bad++;
        checks++;
        if (acc_q.size() != 25 || bad != 0 || m != 0) begin
            errors++;
            $display("FAIL clip_corner: writes=%0d offscreen=%0d mism=%0d want 25/0/0",
                     acc_q.size(), bad, m);
        end
        $display("clip @(155,115): writes=%0d done_cycle=%0d", acc_q.size(), lat);
        run_cell(5'd9, 8'd250, 8'd0, 1'b1, 0, 0, 0, 0, lat, sb, lb);
        checks++;
        if (acc_q.size() != 0) begin
            errors++;
            $display("FAIL clip_offscreen: got %0d writes want 0", acc_q.size());
        end
        checks++;
        if (lat != 82) begin
            errors++;
            $display("FAIL clip_done: done at cycle %0d want 82", lat);
        end
        $display("clip @(250,0): writes=%0d done_cycle=%0d", acc_q.size(), lat);
    endtask

    task automatic test_backpressure();
        int lat, sb, lb, m;
        run_cell(5'd9, 8'd10, 8'd20, 1'b0, 0, 2, 5, 0, lat, sb, lb);
        m = seq_mismatch();
        checks++;
        if (sb != 0 || stall_cnt != 5) begin
            errors++;
            $display("FAIL bp_hold: unstable=%0d stall_cycles=%0d want 0/5", sb, stall_cnt);
        end
        checks++;
        if (acc_q.size() != 17 || m != 0) begin
            errors++;
            $display("FAIL bp_seq: writes=%0d mism=%0d want 17/0", acc_q.size(), m);
        end
        checks++;
        if (lat != 87) begin
            errors++;
            $display("FAIL bp_done: done at cycle %0d want 87", lat);
        end
        $display("backpressure J: writes=%0d stalls=%0d done_cycle=%0d", acc_q.size(), stall_cnt, lat);
    endtask

    task automatic test_start_ignored();
        int lat, sb, lb, m;
        run_cell(5'd3, 8'd40, 8'd60, 1'b1, 0, 0, 0, 1, lat, sb, lb);
        m = seq_mismatch();
        checks++;
        if (lb != 0) begin
            errors++;
            $display("FAIL start_ignored_latch: %0d cycles with changed latch want 0", lb);
        end
        checks++;
        if (m != 0 || lat != 82) begin
            errors++;
            $display("FAIL start_ignored_seq: mism=%0d done=%0d want 0/82", m, lat);
        end
        $display("start spam: writes=%0d done_cycle=%0d", acc_q.size(), lat);
    endtask

    task automatic test_reset_mid();
        int lat, sb, lb, m;
        @(posedge clk); #1;
        start = 1'b1; char_code = 5'd9; org_x = 8'd5; org_y = 8'd5; opaque = 1'b1;
        plot_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #3;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: busy=%b before reset want 1", busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({plot_valid, busy, done} !== 3'b000 || glyph_sel !== 5'd0) begin
            errors++;
            $display("FAIL mid_reset: valid/busy/done=%b sel=%0d want 000/0",
                     {plot_valid, busy, done}, glyph_sel);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        run_cell(5'd9, 8'd5, 8'd5, 1'b1, 0, 0, 0, 0, lat, sb, lb);
        m = seq_mismatch();
        checks++;
        if (m != 0 || acc_q.size() != 80 || lat != 82) begin
            errors++;
            $display("FAIL mid_rerun: mism=%0d writes=%0d done=%0d want 0/80/82", m, acc_q.size(), lat);
        end
        $display("reset mid-scan, rerun: writes=%0d done_cycle=%0d", acc_q.size(), lat);
    endtask

    task automatic test_random();
        int lat, sb, lb, m;
        logic [4:0] code;
        logic [7:0] ox, oy;
        logic       opq;
        for (int t = 0; t < 8; t++) begin
            code = 5'($urandom_range(0, 25));
            ox   = 8'($urandom);
            oy   = (t < 4) ? 8'($urandom_range(100, 255)) : 8'($urandom_range(0, 120));
            opq  = 1'($urandom);
            run_cell(code, ox, oy, opq, 1, 0, 0, 0, lat, sb, lb);
            m = seq_mismatch();
            checks++;
            if (m != 0) begin
                errors++;
                $display("FAIL rand_seq[%0d]: %0d mismatches (got %0d writes want %0d)",
                         t, m, acc_q.size(), exp_q.size());
            end
            checks++;
            if (lat != 82 + stall_cnt) begin
                errors++;
                $display("FAIL rand_done[%0d]: done at cycle %0d want %0d", t, lat, 82 + stall_cnt);
            end
            $display("random cell %0d: code=%0d org=(%0d,%0d) opaque=%b writes=%0d stalls=%0d done=%0d",
                     t, code, ox, oy, opq, acc_q.size(), stall_cnt, lat);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; char_code = '0; org_x = '0; org_y = '0;
        opaque = 1'b0; plot_ready = 1'b1;
        test_reset();
        test_transparent_j();
        test_opaque_j();
        test_clip();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
